// File: rtl/cr16_pkg.sv
// Shared types and helpers for the CR16 write-back stage.
package cr16_pkg;

    localparam int DATA_W    = 16;
    localparam int REG_COUNT = 16;

    typedef logic [3:0]           reg_addr_t;
    typedef logic [REG_COUNT-1:0] reg_onehot_t;
    typedef logic [DATA_W-1:0]    reg_data_t;

    // Which source owns the register-file write port this cycle.
    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_MEM,
        SRC_SKID,
        SRC_ALU
    } wr_src_e;

    function automatic reg_onehot_t onehot_decode(input reg_addr_t addr);
        reg_onehot_t oh;
        oh       = '0;
        oh[addr] = 1'b1;
        return oh;
    endfunction

endpackage

// File: rtl/cr16_writeback_if.sv
// Handshake bundle between the pipeline/memory side (master) and the write-back stage (slave).
interface cr16_writeback_if;

    logic                                     I_ALU_WR_EN;
    cr16_pkg::reg_addr_t                      I_ALU_WR_ADDR;
    cr16_pkg::reg_data_t                      I_ALU_WR_DATA;
    logic                                     I_LD_ISSUE;
    cr16_pkg::reg_addr_t                      I_LD_ADDR;
    logic                                     I_MEM_RD_VALID;
    cr16_pkg::reg_data_t                      I_MEM_RD_DATA;
    cr16_pkg::reg_data_t                      O_REG_BUS;
    cr16_pkg::reg_onehot_t                    O_REG_ENABLE;
    cr16_pkg::reg_onehot_t                    O_REG_BUSY;
    logic                                     O_ALU_STALL;
    logic                                     O_LD_FULL;
    logic                                     O_LD_OVERFLOW;
    logic                                     O_LD_UNDERFLOW;

    modport master (
        output I_ALU_WR_EN, I_ALU_WR_ADDR, I_ALU_WR_DATA,
        output I_LD_ISSUE, I_LD_ADDR, I_MEM_RD_VALID, I_MEM_RD_DATA,
        input  O_REG_BUS, O_REG_ENABLE, O_REG_BUSY, O_ALU_STALL,
        input  O_LD_FULL, O_LD_OVERFLOW, O_LD_UNDERFLOW
    );

    modport slave (
        input  I_ALU_WR_EN, I_ALU_WR_ADDR, I_ALU_WR_DATA,
        input  I_LD_ISSUE, I_LD_ADDR, I_MEM_RD_VALID, I_MEM_RD_DATA,
        output O_REG_BUS, O_REG_ENABLE, O_REG_BUSY, O_ALU_STALL,
        output O_LD_FULL, O_LD_OVERFLOW, O_LD_UNDERFLOW
    );

endinterface

// File: rtl/cr16_ld_tag_fifo.sv
// In-order FIFO of destination tags for outstanding loads; exposes all live tags for the busy scoreboard.
module cr16_ld_tag_fifo
    import cr16_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    push,
    input  logic                    pop,
    input  reg_addr_t               push_tag,
    output logic                    full,
    output logic                    empty,
    output reg_addr_t               head,
    output logic [LD_DEPTH*4-1:0]   tags_flat,
    output logic [LD_DEPTH-1:0]     tags_valid
);

    localparam int PTR_W = $clog2(LD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    reg_addr_t          tags_q [LD_DEPTH];
    reg_addr_t          tags_d [LD_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    // NOTE: every variable gets its default before any branch, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        tags_d   = tags_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            tags_d[wr_ptr_q] = push_tag;
            wr_ptr_d         = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: tag storage is deliberately not reset; entries are only read when the count marks them valid.
    always_ff @(posedge clk) begin
        tags_q <= tags_d;
    end

    // Entry i is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        for (int i = 0; i < LD_DEPTH; i++) begin
            logic [PTR_W-1:0] offset;
            offset             = PTR_W'(i) - rd_ptr_q;
            tags_valid[i]      = {1'b0, offset} < count_q;
            tags_flat[i*4 +: 4] = tags_q[i];
        end
    end

    assign full  = (count_q == CNT_W'(LD_DEPTH));
    assign empty = (count_q == '0);
    assign head  = tags_q[rd_ptr_q];

endmodule

// File: rtl/cr16_writeback.sv
// CR16 write-back stage: arbitrates load returns, skid and ALU writes onto the register-file port.
// Optional feature macro: CR16_WB_ZERO_R0_EN (r0 hardwired to zero: no enable, never busy).
module cr16_writeback
    import cr16_pkg::*;
#(
    parameter int LD_DEPTH = 4
) (
    input  logic              I_CLK,
    input  logic              I_RESET,
    cr16_writeback_if.slave   wb
);

    logic                   fifo_full, fifo_empty;
    reg_addr_t              fifo_head;
    logic [LD_DEPTH*4-1:0]  fifo_tags;
    logic [LD_DEPTH-1:0]    fifo_valid;
    logic                   mem_pop, ld_push, alu_live;
    wr_src_e                wr_src;
    reg_addr_t              wr_addr;
    reg_data_t              wr_data;
    reg_onehot_t            busy;

    logic        skid_valid_q, skid_valid_d;
    reg_addr_t   skid_addr_q, skid_addr_d;
    reg_data_t   skid_data_q, skid_data_d;
    reg_data_t   reg_bus_q, reg_bus_d;
    reg_onehot_t reg_enable_q, reg_enable_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;

    assign mem_pop  = wb.I_MEM_RD_VALID && !fifo_empty;
    assign ld_push  = wb.I_LD_ISSUE && (!fifo_full || mem_pop);
    assign alu_live = wb.I_ALU_WR_EN && !skid_valid_q;

    cr16_ld_tag_fifo #(.LD_DEPTH(LD_DEPTH)) u_tag_fifo (
        .clk        (I_CLK),
        .rst        (I_RESET),
        .push       (ld_push),
        .pop        (mem_pop),
        .push_tag   (wb.I_LD_ADDR),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (fifo_head),
        .tags_flat  (fifo_tags),
        .tags_valid (fifo_valid)
    );

    always_comb begin
        wr_src       = SRC_NONE;
        wr_addr      = '0;
        wr_data      = '0;
        skid_valid_d = skid_valid_q;
        skid_addr_d  = skid_addr_q;
        skid_data_d  = skid_data_q;
        reg_bus_d    = reg_bus_q;
        reg_enable_d = '0;
        overflow_d   = overflow_q | (wb.I_LD_ISSUE && fifo_full && !mem_pop);
        underflow_d  = underflow_q | (wb.I_MEM_RD_VALID && fifo_empty);

        if (mem_pop) begin
            wr_src = SRC_MEM;
        end else if (skid_valid_q) begin
            wr_src = SRC_SKID;
        end else if (alu_live) begin
            wr_src = SRC_ALU;
        end

        // A live ALU write that loses to a load return is parked for the next free cycle.
        if (mem_pop && alu_live) begin
            skid_valid_d = 1'b1;
            skid_addr_d  = wb.I_ALU_WR_ADDR;
            skid_data_d  = wb.I_ALU_WR_DATA;
        end

        case (wr_src)
            SRC_MEM:  begin wr_addr = fifo_head;        wr_data = wb.I_MEM_RD_DATA; end
            SRC_SKID: begin wr_addr = skid_addr_q;      wr_data = skid_data_q;
                            skid_valid_d = 1'b0; end
            SRC_ALU:  begin wr_addr = wb.I_ALU_WR_ADDR; wr_data = wb.I_ALU_WR_DATA; end
            default:  ;
        endcase

        if (wr_src != SRC_NONE) begin
            reg_bus_d    = wr_data;
            reg_enable_d = onehot_decode(wr_addr);
`ifdef CR16_WB_ZERO_R0_EN
            reg_enable_d[0] = 1'b0;
`endif
        end
    end

    always_ff @(posedge I_CLK) begin
        if (I_RESET) begin
            skid_valid_q <= 1'b0;
            skid_addr_q  <= '0;
            skid_data_q  <= '0;
            reg_bus_q    <= '0;
            reg_enable_q <= '0;
            overflow_q   <= 1'b0;
            underflow_q  <= 1'b0;
        end else begin
            skid_valid_q <= skid_valid_d;
            skid_addr_q  <= skid_addr_d;
            skid_data_q  <= skid_data_d;
            reg_bus_q    <= reg_bus_d;
            reg_enable_q <= reg_enable_d;
            overflow_q   <= overflow_d;
            underflow_q  <= underflow_d;
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < LD_DEPTH; i++) begin
            if (fifo_valid[i]) busy |= onehot_decode(fifo_tags[i*4 +: 4]);
        end
`ifdef CR16_WB_ZERO_R0_EN
        busy[0] = 1'b0;
`endif
    end

    assign wb.O_REG_BUS      = reg_bus_q;
    assign wb.O_REG_ENABLE   = reg_enable_q;
    assign wb.O_REG_BUSY     = busy;
    assign wb.O_ALU_STALL    = skid_valid_q;
    assign wb.O_LD_FULL      = fifo_full;
    assign wb.O_LD_OVERFLOW  = overflow_q;
    assign wb.O_LD_UNDERFLOW = underflow_q;

endmodule

// File: tb/tb_cr16_writeback.sv
// Directed self-checking bench for cr16_writeback; outputs sampled 1 time unit after each rising edge.
module tb_cr16_writeback;
    import cr16_pkg::*;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    cr16_writeback_if bus ();

    cr16_writeback #(.LD_DEPTH(4)) dut (
        .I_CLK   (clk),
        .I_RESET (rst),
        .wb      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        bus.I_ALU_WR_EN    = 1'b0;
        bus.I_ALU_WR_ADDR  = '0;
        bus.I_ALU_WR_DATA  = '0;
        bus.I_LD_ISSUE     = 1'b0;
        bus.I_LD_ADDR      = '0;
        bus.I_MEM_RD_VALID = 1'b0;
        bus.I_MEM_RD_DATA  = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input reg_addr_t a, input reg_data_t d);
        bus.I_ALU_WR_EN   = 1'b1;
        bus.I_ALU_WR_ADDR = a;
        bus.I_ALU_WR_DATA = d;
    endtask

    task automatic issue(input reg_addr_t a);
        bus.I_LD_ISSUE = 1'b1;
        bus.I_LD_ADDR  = a;
    endtask

    task automatic ret(input reg_data_t d);
        bus.I_MEM_RD_VALID = 1'b1;
        bus.I_MEM_RD_DATA  = d;
    endtask

    logic [15:0] r0_en_exp;

    initial begin
        n_cmp = 0;
        n_bad = 0;
`ifdef CR16_WB_ZERO_R0_EN
        r0_en_exp = 16'h0000;
`else
        r0_en_exp = 16'h0001;
`endif
        idle();
        rst = 1'b1;
        tick();
        tick();
        check("rst_enable", 32'(bus.O_REG_ENABLE), 32'h0);
        check("rst_bus",    32'(bus.O_REG_BUS),    32'h0);
        check("rst_busy",   32'(bus.O_REG_BUSY),   32'h0);
        check("rst_stall",  32'(bus.O_ALU_STALL),  32'h0);
        check("rst_full",   32'(bus.O_LD_FULL),    32'h0);
        rst = 1'b0;

        // Plain ALU write, one-cycle latency, single-cycle enable
        alu(4'd5, 16'h1234);
        tick();
        idle();
        check("alu_bus", 32'(bus.O_REG_BUS),    32'h1234);
        check("alu_en",  32'(bus.O_REG_ENABLE), 32'h0020);
        tick();
        check("alu_en_clear", 32'(bus.O_REG_ENABLE), 32'h0);

        // Two loads returned in order
        issue(4'd3); tick();
        issue(4'd7); tick();
        idle();
        check("ld_busy2", 32'(bus.O_REG_BUSY), 32'h0088);
        ret(16'hAAAA); tick();
        check("ld_r3_bus",  32'(bus.O_REG_BUS),    32'hAAAA);
        check("ld_r3_en",   32'(bus.O_REG_ENABLE), 32'h0008);
        check("ld_busy1",   32'(bus.O_REG_BUSY),   32'h0080);
        ret(16'hBBBB); tick();
        idle();
        check("ld_r7_bus",  32'(bus.O_REG_BUS),    32'hBBBB);
        check("ld_r7_en",   32'(bus.O_REG_ENABLE), 32'h0080);
        check("ld_busy0",   32'(bus.O_REG_BUSY),   32'h0);

        // ALU write collides with load return -> skid
        issue(4'd9); tick();
        idle();
        ret(16'h9999);
        alu(4'd2, 16'h0042);
        tick();
        idle();
        check("col_mem_bus", 32'(bus.O_REG_BUS),    32'h9999);
        check("col_mem_en",  32'(bus.O_REG_ENABLE), 32'h0200);
        check("col_stall1",  32'(bus.O_ALU_STALL),  32'h1);
        tick();
        check("col_skid_bus", 32'(bus.O_REG_BUS),    32'h0042);
        check("col_skid_en",  32'(bus.O_REG_ENABLE), 32'h0004);
        check("col_stall0",   32'(bus.O_ALU_STALL),  32'h0);
        tick();
        check("col_en_clear", 32'(bus.O_REG_ENABLE), 32'h0);

        // Fill the FIFO, push+pop while full, then overflow
        for (int i = 0; i < 4; i++) begin
            issue(4'd1);
            tick();
        end
        idle();
        check("full_set",  32'(bus.O_LD_FULL),  32'h1);
        check("full_busy", 32'(bus.O_REG_BUSY), 32'h0002);
        issue(4'd1); ret(16'h1111); tick();
        idle();
        check("pp_en",    32'(bus.O_REG_ENABLE),  32'h0002);
        check("pp_full",  32'(bus.O_LD_FULL),     32'h1);
        check("pp_novf",  32'(bus.O_LD_OVERFLOW), 32'h0);
        issue(4'd1); tick();
        idle();
        check("ovf_set",  32'(bus.O_LD_OVERFLOW), 32'h1);
        check("ovf_full", 32'(bus.O_LD_FULL),     32'h1);
        check("ovf_en",   32'(bus.O_REG_ENABLE),  32'h0);
        ret(16'h2222); tick();
        check("drain1_full", 32'(bus.O_LD_FULL),  32'h0);
        tick(); tick();
        check("drain3_busy", 32'(bus.O_REG_BUSY), 32'h0002);
        tick();
        idle();
        check("drain4_busy", 32'(bus.O_REG_BUSY), 32'h0);
        check("drain4_en",   32'(bus.O_REG_ENABLE), 32'h0002);

        // r0 writes (hardwired-zero only with the optional feature)
        alu(4'd0, 16'hFFFF); tick();
        idle();
        check("r0_alu_en", 32'(bus.O_REG_ENABLE), 32'(r0_en_exp));
        issue(4'd0); tick();
        idle();
        check("r0_busy", 32'(bus.O_REG_BUSY), 32'(r0_en_exp));
        ret(16'h5555); tick();
        idle();
        check("r0_ld_en",    32'(bus.O_REG_ENABLE),   32'(r0_en_exp));
        check("r0_popped",   32'(bus.O_REG_BUSY),     32'h0);
        check("r0_no_undf",  32'(bus.O_LD_UNDERFLOW), 32'h0);

        // Underflow, then reset with loads pending
        ret(16'h7777); tick();
        idle();
        check("undf_en",  32'(bus.O_REG_ENABLE),   32'h0);
        check("undf_set", 32'(bus.O_LD_UNDERFLOW), 32'h1);
        issue(4'd4); tick();
        issue(4'd6); tick();
        idle();
        check("pend_busy", 32'(bus.O_REG_BUSY), 32'h0050);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mrst_en",   32'(bus.O_REG_ENABLE),   32'h0);
        check("mrst_bus",  32'(bus.O_REG_BUS),      32'h0);
        check("mrst_busy", 32'(bus.O_REG_BUSY),     32'h0);
        check("mrst_full", 32'(bus.O_LD_FULL),      32'h0);
        check("mrst_ovf",  32'(bus.O_LD_OVERFLOW),  32'h0);
        check("mrst_undf", 32'(bus.O_LD_UNDERFLOW), 32'h0);
        ret(16'h8888); tick();
        idle();
        check("post_rst_undf", 32'(bus.O_LD_UNDERFLOW), 32'h1);
        check("post_rst_en",   32'(bus.O_REG_ENABLE),   32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cr16_writeback.md
Name: cr16_writeback

Overview:
- Write-back stage that directly drives the CR16 register file's write bus and one-hot write enable.
- Merges ALU result writes and in-order memory load returns into a single registered write per cycle.
- Tracks destination registers of outstanding loads in a tag FIFO.
- Exports a per-register busy scoreboard so decode can stall on load-use hazards.

Parameters:
- LD_DEPTH, 4, number of outstanding loads tracked (power of two, >=2).
- DATA_W, 16, register data width.
- REG_COUNT, 16, number of architectural registers.

Ports:
- I_CLK  in  1  system clock, all state on rising edge.
- I_RESET  in  1  synchronous, active-high reset.
- I_ALU_WR_EN  in  1  ALU result valid this cycle.
- I_ALU_WR_ADDR  in  4  ALU destination register.
- I_ALU_WR_DATA  in  DATA_W  ALU result.
- I_LD_ISSUE  in  1  load issued to memory this cycle.
- I_LD_ADDR  in  4  destination register of the issued load.
- I_MEM_RD_VALID  in  1  load data returning (strictly in issue order).
- I_MEM_RD_DATA  in  DATA_W  returned load data.
- O_REG_BUS  out  DATA_W  write data to register file.
- O_REG_ENABLE  out  REG_COUNT  one-hot write enable to register file.
- O_REG_BUSY  out  REG_COUNT  bit n set while any pending load targets register n.
- O_ALU_STALL  out  1  skid buffer occupied; upstream must hold its ALU write.
- O_LD_FULL  out  1  tag FIFO holds LD_DEPTH entries.
- O_LD_OVERFLOW  out  1  sticky: load issued while full.
- O_LD_UNDERFLOW  out  1  sticky: memory return while FIFO empty.

Behaviour:
- Reset (I_RESET=1 at edge):
  - O_REG_BUS=0, O_REG_ENABLE=0.
  - Tag FIFO and skid buffer emptied.
  - Both sticky flags cleared.
  - O_REG_BUSY=0, O_ALU_STALL=0, O_LD_FULL=0.
  - Reset mid-operation discards all pending loads; a later I_MEM_RD_VALID sets O_LD_UNDERFLOW.
- Write path latency: 1 cycle. A write selected in cycle N appears on O_REG_BUS/O_REG_ENABLE in cycle N+1 for exactly one cycle. O_REG_ENABLE is zero otherwise.
- Write source priority each cycle:
  1. Memory return, if I_MEM_RD_VALID and FIFO non-empty.
  2. Skid entry.
  3. Live ALU write.
- Skid buffer (1 entry):
  - Captures the live ALU write when it loses arbitration to a memory return.
  - O_ALU_STALL = skid valid (registered).
  - While O_ALU_STALL=1, I_ALU_WR_EN is ignored.
  - The skid drains in the first cycle with no valid memory return.
- Memory return:
  - Pops the FIFO head; the write address is the head tag.
  - If the FIFO is empty, the write is suppressed and O_LD_UNDERFLOW is set.
- Load issue:
  - Pushes I_LD_ADDR.
  - When full with no simultaneous pop, the push is dropped and O_LD_OVERFLOW is set.
  - Push and pop in the same cycle are legal at any occupancy, including full.
- O_LD_FULL: combinational from FIFO count.
- O_REG_BUSY: combinational OR of one-hot(tag) over all valid FIFO entries. A register stays busy until its last pending load returns.
- ALU write to a busy register: performed; busy unchanged. Preventing this WAW hazard is decode's responsibility.
- Tag FIFO pointers wrap modulo LD_DEPTH. Count is $clog2(LD_DEPTH)+1 bits.

Optional Feature:
- Macro: CR16_WB_ZERO_R0_EN.
- Defined:
  - Any write targeting r0 is consumed normally (FIFO pop, skid drain), but O_REG_ENABLE stays 0 that cycle.
  - O_REG_BUSY[0] is forced to 0.
- Undefined: r0 is an ordinary register.

Decomposition:
- cr16_pkg holds:
  - DATA_W, REG_COUNT.
  - typedef reg_addr_t (logic [3:0]).
  - typedef reg_onehot_t (logic [REG_COUNT-1:0]).
  - function onehot_decode(reg_addr_t) returning reg_onehot_t.
- Sub-module cr16_ld_tag_fifo (parameter LD_DEPTH):
  - push/pop/full/empty/head.
  - Flat vector of valid tags, consumed by the busy computation.

Test Plan:
- ALU write r5=0x1234 at cycle N, no loads -> cycle N+1: O_REG_BUS=0x1234, O_REG_ENABLE=0x0020; cycle N+2: O_REG_ENABLE=0.
- Issue loads to r3 then r7; return 0xAAAA then 0xBBBB -> writes r3=0xAAAA (enable 0x0008), then r7=0xBBBB (enable 0x0080). O_REG_BUSY goes 0x0088 -> 0x0080 -> 0.
- ALU write r2=0x0042 in the same cycle as the load return for r9=0x9999 -> r9 written first, O_ALU_STALL=1 for one cycle, r2=0x0042 written the next cycle.
- Issue 4 loads to r1 -> O_LD_FULL=1, O_REG_BUSY=0x0002 until the 4th return. A 5th issue sets O_LD_OVERFLOW. Issue+return together while full keeps count 4 with no overflow.
- I_MEM_RD_VALID with empty FIFO -> O_REG_ENABLE stays 0, O_LD_UNDERFLOW=1. Assert I_RESET with 2 loads pending -> next cycle all outputs 0 and O_REG_BUSY=0.
- With CR16_WB_ZERO_R0_EN: ALU write r0=0xFFFF -> O_REG_ENABLE=0. Load to r0 -> O_REG_BUSY[0]=0 and its return pops the FIFO.
